// File: rtl/writeback_retire_pkg.sv
// Purpose: shared widths and the retire-buffer entry layout used by the
//          memory stage and the writeback/retire block.
// Contents: XLEN/RA_W/EXC_W/CNT_W widths, default buffer geometry,
//           ret_entry_t payload and its packed width.
package writeback_retire_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RA_W     = 5;
  localparam int unsigned EXC_W    = 4;
  localparam int unsigned CNT_W    = 64;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned WB_RET_W = 2;

  // One completed instruction waiting to retire.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               rd_wen;
    logic [RA_W-1:0]    rd_addr;
    logic [XLEN-1:0]    result;
    logic               exc_valid;
    logic [EXC_W-1:0]   exc_code;
    logic               halt;
  } ret_entry_t;

  localparam int unsigned RET_ENTRY_W = $bits(ret_entry_t);

endpackage

// File: rtl/writeback_retire_if.sv
// Purpose: memory-stage -> writeback enqueue handshake.
// Signals: in_valid/in_ready handshake plus the completed-instruction
//          fields (pc, instr, rd_wen, rd_addr, result, exc_valid,
//          exc_code, halt).
// Modports: master = memory stage (producer), slave = writeback_retire.
interface writeback_retire_if;
  import writeback_retire_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_rd_wen;
  logic [RA_W-1:0]    in_rd_addr;
  logic [XLEN-1:0]    in_result;
  logic               in_exc_valid;
  logic [EXC_W-1:0]   in_exc_code;
  logic               in_halt;

  modport master (
    output in_valid, in_pc, in_instr, in_rd_wen, in_rd_addr, in_result,
           in_exc_valid, in_exc_code, in_halt,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_rd_wen, in_rd_addr, in_result,
           in_exc_valid, in_exc_code, in_halt,
    output in_ready
  );

endinterface

// File: rtl/writeback_retire_fifo.sv
// Purpose: in-order retire buffer storage (retire_fifo): DEPTH entries,
//          single push, multi-pop of up to RET_W entries per cycle.
// Ports: clk, reset (sync, active-high), i_push/i_push_data enqueue,
//        i_pop_n entries removed at the edge, i_clear empties the buffer,
//        o_full, o_lane_data/o_lane_occ = head+0..head+RET_W-1 view.
module writeback_retire_fifo
  import writeback_retire_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  parameter  int unsigned RET_W = WB_RET_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = $clog2(DEPTH + 1),
  localparam int unsigned POP_W = $clog2(RET_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  ret_entry_t       i_push_data,
  input  logic [POP_W-1:0] i_pop_n,
  input  logic             i_clear,
  output logic             o_full,
  output ret_entry_t       o_lane_data [RET_W],
  output logic [RET_W-1:0] o_lane_occ
);

  ret_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      r_head  <= r_head + PTR_W'(i_pop_n);
      r_count <= r_count + OCC_W'(i_push) - OCC_W'(i_pop_n);
    end
  end

  // Payload storage needs no reset; occupancy comes from r_count.
  always_ff @(posedge clk) begin
    if (i_push && !reset && !i_clear) r_mem[r_tail] <= i_push_data;
  end

  // Head-relative lane view; occupancy from the count, not pointer equality.
  always_comb begin
    for (int i = 0; i < int'(RET_W); i++) begin
      o_lane_data[i] = r_mem[r_head + PTR_W'(i)];
      o_lane_occ[i]  = (OCC_W'(i) < r_count);
    end
  end

  assign o_full = (r_count == OCC_W'(DEPTH));

endmodule

// File: rtl/writeback_retire.sv
// Purpose: buffered multi-lane writeback/retire stage between the memory
//          stage and the register file / CSR unit.
// Ports: clk, reset (sync, active-high); bus = enqueue handshake (slave);
//        trap_vector flush target; wr_en/wr_addr/wr_data per-lane regfile
//        writes; exc_take/exc_pc/exc_code to CSR; flush/flush_addr
//        redirect; halt_out sticky halt; instret retired count.
module writeback_retire
  import writeback_retire_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  parameter  int unsigned RET_W = WB_RET_W,
  localparam int unsigned POP_W = $clog2(RET_W + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  writeback_retire_if.slave      bus,
  input  logic [XLEN-1:0]        trap_vector,
  output logic [RET_W-1:0]       wr_en,
  output logic [RET_W*RA_W-1:0]  wr_addr,
  output logic [RET_W*XLEN-1:0]  wr_data,
  output logic                   exc_take,
  output logic [XLEN-1:0]        exc_pc,
  output logic [EXC_W-1:0]       exc_code,
  output logic                   flush,
  output logic [XLEN-1:0]        flush_addr,
  output logic                   halt_out,
  output logic [CNT_W-1:0]       instret
);

  ret_entry_t       w_lane [RET_W];
  ret_entry_t       w_in_entry;
  logic [RET_W-1:0] w_occ;
  logic [RET_W-1:0] w_elig;
  logic [RET_W-1:0] w_ret;
  logic [POP_W-1:0] w_pop_n;
  logic             w_full;
  logic             w_exc;
  logic             w_halt_hit;
  logic             w_push;
  logic             r_halt;
  logic [CNT_W-1:0] r_instret;

  // Pack the enqueue fields into a buffer entry.
  always_comb begin
    w_in_entry           = '0;
    w_in_entry.pc        = bus.in_pc;
    w_in_entry.instr     = bus.in_instr;
    w_in_entry.rd_wen    = bus.in_rd_wen;
    w_in_entry.rd_addr   = bus.in_rd_addr;
    w_in_entry.result    = bus.in_result;
    w_in_entry.exc_valid = bus.in_exc_valid;
    w_in_entry.exc_code  = bus.in_exc_code;
    w_in_entry.halt      = bus.in_halt;
  end

  assign bus.in_ready = !w_full && !r_halt && !w_exc && !reset;
  assign w_push       = bus.in_valid && bus.in_ready;

  writeback_retire_fifo #(
    .DEPTH (DEPTH),
    .RET_W (RET_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_in_entry),
    .i_pop_n     (w_pop_n),
    .i_clear     (w_exc),
    .o_full      (w_full),
    .o_lane_data (w_lane),
    .o_lane_occ  (w_occ)
  );

  // Lane eligibility: an in-order chain that stops after an excepting or
  // halting lane. Reset suppresses all retirement in its cycle.
  always_comb begin
    logic v_chain;
    v_chain    = !r_halt && !reset;
    w_elig     = '0;
    w_ret      = '0;
    w_exc      = 1'b0;
    w_halt_hit = 1'b0;
    w_pop_n    = '0;
    exc_pc     = '0;
    exc_code   = '0;
    for (int i = 0; i < int'(RET_W); i++) begin
      w_elig[i] = w_occ[i] && v_chain;
      w_ret[i]  = w_elig[i] && !w_lane[i].exc_valid;
      if (w_elig[i] && w_lane[i].exc_valid) begin
        w_exc    = 1'b1;
        exc_pc   = w_lane[i].pc;
        exc_code = w_lane[i].exc_code;
      end
      if (w_ret[i] && w_lane[i].halt) w_halt_hit = 1'b1;
      if (w_ret[i]) w_pop_n = w_pop_n + POP_W'(1);
      v_chain = w_elig[i] && !w_lane[i].exc_valid && !w_lane[i].halt;
    end
  end

  // Regfile writes: x0 suppressed; same-cycle WAW keeps only the youngest.
  always_comb begin
    logic [RET_W-1:0] v_base;
    logic             v_kill;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    v_base  = '0;
    v_kill  = 1'b0;
    for (int i = 0; i < int'(RET_W); i++) begin
      v_base[i] = w_ret[i] && w_lane[i].rd_wen && (w_lane[i].rd_addr != '0);
    end
    for (int i = 0; i < int'(RET_W); i++) begin
      v_kill = 1'b0;
      for (int j = i + 1; j < int'(RET_W); j++) begin
        if (v_base[j] && (w_lane[j].rd_addr == w_lane[i].rd_addr)) v_kill = 1'b1;
      end
      wr_en[i]                = v_base[i] && !v_kill;
      wr_addr[i*RA_W +: RA_W] = w_lane[i].rd_addr;
      wr_data[i*XLEN +: XLEN] = w_lane[i].result;
    end
  end

  assign exc_take   = w_exc;
  assign flush      = w_exc;
  assign flush_addr = trap_vector;

  // Sticky halt and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt    <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_halt_hit) r_halt <= 1'b1;
      r_instret <= r_instret + CNT_W'(w_pop_n);
    end
  end

  assign halt_out = r_halt;
  assign instret  = r_instret;

`ifdef SIMULATE
  // Retirement trace: one line per retired lane.
  always @(posedge clk) begin
    for (int i = 0; i < int'(RET_W); i++) begin
      if (w_ret[i]) begin
        $display("%0t pc=%h instr=%h rd=%0d result=%h", $time,
                 w_lane[i].pc, w_lane[i].instr, w_lane[i].rd_addr, w_lane[i].result);
      end
    end
  end
`endif

endmodule
